id_ex_reg: RTL
==============

# id_ex_reg

Pipeline register between instruction decode and execute. It captures the two register-file read operands plus the decoded instruction fields each cycle. It supports stall (hold) and flush (bubble insertion). It applies write-back bypass, so the execute stage never sees a stale operand when write-back writes the same register in the capture cycle or during a hold. A saturating bubble counter is provided for performance observation.

## Interface
- CTRL_W, 16, width of the opaque decoded-control bundle
- CNT_W, 16, width of the bubble counter

- clk  input  1  clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hold current contents
- flush  input  1  replace contents with a bubble
- id_valid  input  1  decode slot holds a real instruction
- id_pc  input  32  instruction PC
- id_rs, id_rt, id_rd  input  5 each  source/destination register numbers
- id_data1, id_data2  input  32 each  register-file read data for rs/rt
- id_imm  input  32  extended immediate
- id_ctrl  input  CTRL_W  decoded control bundle
- wb_wr  input  1  write-back write enable
- wb_addr  input  5  write-back register number
- wb_data  input  32  write-back data
- ex_valid  output  1  execute slot valid
- ex_pc, ex_imm  output  32 each  registered copies
- ex_rs, ex_rt, ex_rd  output  5 each  registered copies
- ex_data1, ex_data2  output  32 each  registered, bypass-corrected operands
- ex_ctrl  output  CTRL_W  registered control; all-zero on bubble
- bubble_count  output  CNT_W  saturating count of cycles with ex_valid=0

## Operation
- The block has one of three actions per rising edge. Priority is reset > flush > stall > load.
- Reset:
  - All outputs go to 0, including bubble_count.
- Flush (flush=1, regardless of stall):
  - ex_valid=0 and ex_ctrl=0.
  - ex_pc, ex_rs, ex_rt, ex_rd, ex_imm, ex_data1 and ex_data2 go to 0.
- Stall (stall=1, flush=0):
  - All fields hold, except the held-operand bypass below.
- Load (stall=0, flush=0):
  - All ex_* fields take their id_* counterparts.
  - ex_valid takes id_valid.
  - ex_data1/ex_data2 take the capture-bypass value.
- Bypass hit: wb_wr=1, wb_addr!=0 and wb_addr equals the register number in question.
- Capture bypass (load):
  - ex_data1 = wb_data if a bypass hit occurs on id_rs, else id_data1.
  - ex_data2 likewise on id_rt.
- Held-operand bypass (stall):
  - If a bypass hit occurs on ex_rs, ex_data1 takes wb_data; else it holds.
  - ex_data2 likewise on ex_rt.
  - Applies whether or not ex_valid=1.
- Register 0 is never bypassed. Data for register 0 always passes or holds unmodified.
- When rs==rt and both hit, both operands take wb_data.
- bubble_count:
  - Increments by 1 on every non-reset edge where the new ex_valid is 0.
  - Saturates at all-ones; it does not wrap.

## Timing
- Latency: id_* sampled at edge N appears on ex_* after edge N. There is no combinational path from inputs to outputs.
- wb_* is sampled at the same edge as id_*. Write-back committing on that edge is therefore reflected in the captured operand.
- Stall for K cycles: outputs remain constant for K edges, apart from bypass updates to ex_data1/ex_data2.
- flush and stall both 1: a bubble is produced and the incoming instruction is discarded.
- Reset asserted mid-stall or mid-flush: all outputs are 0 after that edge.
- The first edge after reset deasserts is a normal load.
- bubble_count is 0 immediately after reset. The reset edge itself is not counted.

## Test plan
- Reset, then load id_valid=1, id_pc=0x00400004, id_rs=3, id_data1=0x11 with wb_wr=0 -> after one edge ex_valid=1, ex_pc=0x00400004, ex_data1=0x11.
- Load id_rs=5, id_rt=5, both id_data=0x1 with wb_wr=1, wb_addr=5, wb_data=0xDEADBEEF -> ex_data1=ex_data2=0xDEADBEEF. Repeat with wb_addr=0, id_rs=id_rt=0, id_data=0x0 -> operands stay 0x0.
- Load ex_rt=7 (data 0x22), then stall 3 cycles with a write of 0xCAFEF00D to r7 in the second stall cycle -> ex_data2=0x22 for the first stall edge and 0xCAFEF00D afterwards; all other fields constant.
- Assert flush and stall together with id_valid=1 -> ex_valid=0, ex_ctrl=0, bubble_count increments by 1.
- With CNT_W=4, hold id_valid=0 for 20 cycles -> bubble_count reaches 15 and stays at 15. Assert reset -> bubble_count=0 and all ex_* are 0 on the next edge.

Source files
------------

// File: rtl/id_ex_reg.sv
// rtl/id_ex_reg.sv - ID/EX pipeline register with stall, flush, write-back bypass and bubble counter
module id_ex_reg #(
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [31:0]       id_pc,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [31:0]       id_data1,
  input  logic [31:0]       id_data2,
  input  logic [31:0]       id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              wb_wr,
  input  logic [4:0]        wb_addr,
  input  logic [31:0]       wb_data,
  output logic              ex_valid,
  output logic [31:0]       ex_pc,
  output logic [31:0]       ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [31:0]       ex_data1,
  output logic [31:0]       ex_data2,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  logic              valid_q, valid_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       imm_q, imm_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic [31:0]       data1_q, data1_d;
  logic [31:0]       data2_q, data2_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // A write-back hit on a register number; r0 is hard-wired and never forwarded.
  function automatic logic wb_hit(input logic [4:0] reg_num);
    return wb_wr && (wb_addr != 5'd0) && (wb_addr == reg_num);
  endfunction

  // Next-state selection: flush beats stall beats load; reset is applied in the register process.
  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    imm_d   = imm_q;
    rs_d    = rs_q;
    rt_d    = rt_q;
    rd_d    = rd_q;
    data1_d = data1_q;
    data2_d = data2_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
      imm_d   = '0;
      rs_d    = '0;
      rt_d    = '0;
      rd_d    = '0;
      data1_d = '0;
      data2_d = '0;
      ctrl_d  = '0;
    end else if (stall) begin
      // Held operands still track write-back so execute never sees stale data after the stall.
      if (wb_hit(rs_q)) data1_d = wb_data;
      if (wb_hit(rt_q)) data2_d = wb_data;
    end else begin
      valid_d = id_valid;
      pc_d    = id_pc;
      imm_d   = id_imm;
      rs_d    = id_rs;
      rt_d    = id_rt;
      rd_d    = id_rd;
      ctrl_d  = id_ctrl;
      data1_d = wb_hit(id_rs) ? wb_data : id_data1;
      data2_d = wb_hit(id_rt) ? wb_data : id_data2;
    end
  end

  // Bubble counter advances whenever the slot about to be presented is empty, saturating at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (!valid_d && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // Pipeline state register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      imm_q   <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      rd_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      imm_q   <= imm_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_pc        = pc_q;
  assign ex_imm       = imm_q;
  assign ex_rs        = rs_q;
  assign ex_rt        = rt_q;
  assign ex_rd        = rd_q;
  assign ex_data1     = data1_q;
  assign ex_data2     = data2_q;
  assign ex_ctrl      = ctrl_q;
  assign bubble_count = cnt_q;

endmodule
